// File: rtl/nx_soft_reset_ctrl.sv
// rtl/nx_soft_reset_ctrl.sv - soft-reset sequencer: host/watchdog trigger, hold-off, fixed pulse, release wait
// Clocked and reset by the hard reset only, so it survives the soft reset it issues.
module nx_soft_reset_ctrl #(
  parameter int PULSE_CYCLES = 4,
  parameter int DELAY_W      = 8,
  parameter int WDOG_W       = 16,
  parameter int COUNT_W      = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  input  logic [DELAY_W-1:0] req_delay_i,
  output logic               req_ready_o,
  input  logic               wdog_en_i,
  input  logic               wdog_kick_i,
  input  logic [WDOG_W-1:0]  wdog_limit_i,
  input  logic               rst_internal_i,
  output logic               rst_soft_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         cause_o,
  output logic [COUNT_W-1:0] count_o
);

  localparam int PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HOST = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLDOFF = 3'd1,
    S_PULSE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DELAY_W-1:0]  r_hold_cnt;
  logic [DELAY_W-1:0]  w_hold_cnt_nxt;
  logic [PCNT_W-1:0]   r_pulse_cnt;
  logic [PCNT_W-1:0]   w_pulse_cnt_nxt;
  logic [WDOG_W-1:0]   r_wdog_cnt;
  logic [WDOG_W-1:0]   w_wdog_cnt_nxt;
  logic [WDOG_W-1:0]   w_wdog_inc;
  logic [1:0]          r_cause;
  logic [1:0]          w_cause_nxt;
  logic [COUNT_W-1:0]  r_count;
  logic                r_req_ready;
  logic                r_rst_soft;
  logic                r_busy;
  logic                r_done;
  logic                w_accept;
  logic                w_wdog_active;
  logic                w_wdog_expire;

  // r_req_ready is only set while in IDLE, so it doubles as the accept qualifier.
  assign w_accept      = req_valid_i & r_req_ready;
  assign w_wdog_active = (r_state == S_IDLE) & wdog_en_i & (wdog_limit_i != '0);
  assign w_wdog_inc    = r_wdog_cnt + WDOG_W'(1);
  // Expiry fires on the cycle the increment would reach the limit, so the pulse
  // starts exactly wdog_limit_i cycles after the watchdog starts counting.
  assign w_wdog_expire = w_wdog_active & ~wdog_kick_i & (w_wdog_inc == wdog_limit_i);

  always_comb begin
    w_wdog_cnt_nxt = w_wdog_inc;
    if (!w_wdog_active || wdog_kick_i || w_accept || w_wdog_expire) begin
      w_wdog_cnt_nxt = '0;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_pulse_cnt_nxt = r_pulse_cnt;
    w_cause_nxt     = r_cause;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cause_nxt = CAUSE_HOST;
          if (req_delay_i == '0) begin
            w_next          = S_PULSE;
            w_pulse_cnt_nxt = PULSE_LAST;
          end else begin
            w_next         = S_HOLDOFF;
            w_hold_cnt_nxt = req_delay_i;
          end
        end else if (w_wdog_expire) begin
          w_cause_nxt     = CAUSE_WDOG;
          w_next          = S_PULSE;
          w_pulse_cnt_nxt = PULSE_LAST;
        end
      end
      S_HOLDOFF: begin
        if (r_hold_cnt <= DELAY_W'(1)) begin
          w_next          = S_PULSE;
          w_hold_cnt_nxt  = '0;
          w_pulse_cnt_nxt = PULSE_LAST;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - DELAY_W'(1);
        end
      end
      S_PULSE: begin
        if (r_pulse_cnt == '0) begin
          w_next = S_RELEASE;
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt - PCNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (!rst_internal_i) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= '0;
      r_pulse_cnt <= '0;
      r_wdog_cnt  <= '0;
      r_cause     <= CAUSE_NONE;
    end else begin
      r_state     <= w_next;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_wdog_cnt  <= w_wdog_cnt_nxt;
      r_cause     <= w_cause_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req_ready <= 1'b0;
      r_rst_soft  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_req_ready <= (w_next == S_IDLE);
      r_rst_soft  <= (w_next == S_PULSE);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      if ((w_next == S_DONE) && (r_count != '1)) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign req_ready_o = r_req_ready;
  assign rst_soft_o  = r_rst_soft;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign cause_o     = r_cause;
  assign count_o     = r_count;

endmodule

// File: tb/tb_nx_soft_reset_ctrl.sv
// tb/tb_nx_soft_reset_ctrl.sv - directed self-checking bench for nx_soft_reset_ctrl
module tb_nx_soft_reset_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [7:0]  req_delay;
  logic        req_ready;
  logic        wdog_en;
  logic        wdog_kick;
  logic [15:0] wdog_limit;
  logic        rst_internal;
  logic        rst_soft;
  logic        busy;
  logic        done;
  logic [1:0]  cause;
  logic [7:0]  count;

  logic [1:0]  stretch = 2'd0;
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;

  always #5 clk = ~clk;

  // Downstream reset model: follows the soft pulse and stays up 3 more cycles.
  always @(posedge clk) begin
    if (rst_soft) stretch <= 2'd3;
    else if (stretch != 2'd0) stretch <= stretch - 2'd1;
  end
  assign rst_internal = rst_soft | (stretch != 2'd0);

  nx_soft_reset_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_delay_i    (req_delay),
    .req_ready_o    (req_ready),
    .wdog_en_i      (wdog_en),
    .wdog_kick_i    (wdog_kick),
    .wdog_limit_i   (wdog_limit),
    .rst_internal_i (rst_internal),
    .rst_soft_o     (rst_soft),
    .busy_o         (busy),
    .done_o         (done),
    .cause_o        (cause),
    .count_o        (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Called at the first negedge after an accept/trigger edge; follows one soft reset to done_o.
  task automatic watch(input string tag, input int exp_lat);
    int first = -1;
    int width = 0;
    int rdy_bad = 0;
    bit done_seen = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      if (i > 0) @(negedge clk);
      if (rst_soft) begin
        if (first < 0) first = i;
        width++;
      end
      if (req_ready) rdy_bad++;
      if (done) done_seen = 1'b1;
    end
    if (done_seen) exp_count++;
    check({tag, "_latency"}, first, exp_lat);
    check({tag, "_width"}, width, 4);
    check({tag, "_ready_busy"}, rdy_bad, 0);
    check({tag, "_done"}, done_seen, 1);
    check({tag, "_count"}, count, exp_count);
  endtask

  task automatic wait_soft(input string tag, input int exp_cycles);
    int n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rst_soft) begin
        n = i;
        break;
      end
    end
    check(tag, n, exp_cycles);
  endtask

  initial begin
    int fired;
    int dones;
    bit done_bad;
    rst = 1'b1; req_valid = 1'b0; req_delay = '0;
    wdog_en = 1'b0; wdog_kick = 1'b0; wdog_limit = '0;
    repeat (3) @(negedge clk);
    check("rst_soft", rst_soft, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cause", cause, 0);
    check("rst_count", count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_rise", req_ready, 1);

    // 1: host, no hold-off
    req_valid = 1'b1; req_delay = 8'd0;
    @(negedge clk);
    req_valid = 1'b0;
    check("t1_cause", cause, 1);
    watch("t1", 0);

    // 2: hold-off of 5, second request held valid through the first
    @(negedge clk);
    req_valid = 1'b1; req_delay = 8'd5;
    @(negedge clk);
    watch("t2a", 5);
    @(negedge clk);
    check("t2_ready_after_done", req_ready, 1);
    @(negedge clk);
    check("t2_second_accepted", busy, 1);
    req_valid = 1'b0;
    watch("t2b", 5);

    // 3: watchdog expiry, then kicks every 8 cycles keep it quiet
    @(negedge clk);
    @(negedge clk);
    wdog_limit = 16'd10; wdog_en = 1'b1;
    wait_soft("t3_wdog_delay", 10);
    check("t3_cause", cause, 2);
    watch("t3", 0);
    fired = 0;
    for (int i = 0; i < 60; i++) begin
      wdog_kick = (i % 8 == 7);
      @(negedge clk);
      if (rst_soft) fired++;
    end
    wdog_kick = 1'b0;
    check("t3_kick_no_fire", fired, 0);
    wdog_en = 1'b0;

    // 4: host request coincides with watchdog expiry
    @(negedge clk);
    wdog_en = 1'b1;
    repeat (9) @(negedge clk);
    req_valid = 1'b1; req_delay = 8'd0;
    @(negedge clk);
    req_valid = 1'b0;
    check("t4_cause_host", cause, 1);
    watch("t4", 0);
    wait_soft("t4_wdog_restart", 11);
    check("t4_cause_wdog", cause, 2);
    watch("t4w", 0);
    wdog_en = 1'b0;

    // 5: hard reset in the middle of the pulse
    @(negedge clk);
    req_valid = 1'b1; req_delay = 8'd0;
    @(negedge clk);
    req_valid = 1'b0;
    check("t5_in_pulse", rst_soft, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_soft_off", rst_soft, 0);
    check("t5_count", count, 0);
    check("t5_cause", cause, 0);
    check("t5_busy", busy, 0);
    done_bad = done;
    repeat (3) begin
      @(negedge clk);
      if (done) done_bad = 1'b1;
    end
    check("t5_no_done", done_bad, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_back", req_ready, 1);

    // 6: 260 back-to-back host resets, counter saturates
    req_valid = 1'b1; req_delay = 8'd0;
    dones = 0;
    for (int i = 0; i < 6000 && dones < 260; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 254) check("t6_count_254", count, 254);
      end
    end
    req_valid = 1'b0;
    check("t6_dones", dones, 260);
    check("t6_saturated", count, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
